// File: rtl/cpu_fetch_pkg.sv
// Shared types and widths for the CPU fetch responder (iTLB + direct-mapped I-cache).
// Width macros are guarded so a project-wide define header takes precedence.
`ifndef VIRTUAL_ADDR_WIDTH
`define VIRTUAL_ADDR_WIDTH 32
`endif
`ifndef PHYSICAL_ADDR_WIDTH
`define PHYSICAL_ADDR_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

package cpu_fetch_pkg;
  localparam int VA_W        = `VIRTUAL_ADDR_WIDTH;
  localparam int PA_W        = `PHYSICAL_ADDR_WIDTH;
  localparam int INSTR_W     = `INSTR_WIDTH;
  localparam int INSTR_BYTES = INSTR_W / 8;

  localparam int ITLB_ENTRIES_DEF     = 4;
  localparam int PAGE_OFFSET_BITS_DEF = 12;
  localparam int ICACHE_LINES_DEF     = 8;
  localparam int LINE_WORDS_DEF       = 4;

  localparam int VPN_W      = VA_W - PAGE_OFFSET_BITS_DEF;
  localparam int PPN_W      = PA_W - PAGE_OFFSET_BITS_DEF;
  localparam int BYTE_OFF_W = $clog2(INSTR_BYTES);
  localparam int TAG_W      = PA_W - $clog2(ICACHE_LINES_DEF) - $clog2(LINE_WORDS_DEF) - BYTE_OFF_W;

  typedef enum logic {IDLE, REFILL} fetch_state_e;

  typedef struct packed {
    logic             valid;
    logic [VPN_W-1:0] vpn;
    logic [PPN_W-1:0] ppn;
  } itlb_entry_t;

  typedef struct packed {
    logic                                   valid;
    logic [TAG_W-1:0]                       tag;
    logic [LINE_WORDS_DEF-1:0][INSTR_W-1:0] words;
  } cache_line_t;
endpackage

// File: rtl/cpu_fetch_responder_if.sv
// Fetch request/response bundle plus the line-refill memory port.
interface cpu_fetch_responder_if;
  import cpu_fetch_pkg::*;

  logic                               tlb_enable;
  logic                               tlb_write;
  logic [VA_W-1:0]                    tlb_addr;
  logic [PA_W-1:0]                    tlb_data;
  logic [PA_W-1:0]                    pc;
  logic                               jump;
  logic [PA_W-1:0]                    jump_pc;
  logic                               exception;
  logic                               tlb_hit;
  logic [INSTR_W-1:0]                 instr;
  logic                               cache_hit;
  logic [PA_W-1:0]                    next_pc;
  logic                               mem_req;
  logic [PA_W-1:0]                    mem_addr;
  logic                               mem_ack;
  logic [LINE_WORDS_DEF*INSTR_W-1:0]  mem_data;

  modport master (
    output tlb_enable, tlb_write, tlb_addr, tlb_data, pc, jump, jump_pc, exception,
           mem_ack, mem_data,
    input  tlb_hit, instr, cache_hit, next_pc, mem_req, mem_addr
  );

  modport slave (
    input  tlb_enable, tlb_write, tlb_addr, tlb_data, pc, jump, jump_pc, exception,
           mem_ack, mem_data,
    output tlb_hit, instr, cache_hit, next_pc, mem_req, mem_addr
  );
endinterface

// File: rtl/cpu_itlb.sv
// Fully-associative iTLB: combinational lookup on current contents, round-robin fill,
// in-place overwrite when the written VPN is already resident.
module cpu_itlb
  import cpu_fetch_pkg::*;
#(
  parameter int ENTRIES = ITLB_ENTRIES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [VPN_W-1:0] wr_vpn,
  input  logic [PPN_W-1:0] wr_ppn,
  input  logic [VPN_W-1:0] lk_vpn,
  output logic             lk_hit,
  output logic [PPN_W-1:0] lk_ppn
);
  localparam int PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  itlb_entry_t      tbl [ENTRIES];
  logic [PTR_W-1:0] wr_ptr;
  logic             wr_match;
  logic [PTR_W-1:0] wr_match_idx;

  always_comb begin
    lk_hit       = 1'b0;
    lk_ppn       = '0;
    wr_match     = 1'b0;
    wr_match_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (tbl[i].valid && tbl[i].vpn == lk_vpn) begin
        lk_hit = 1'b1;
        lk_ppn = tbl[i].ppn;
      end
      if (tbl[i].valid && tbl[i].vpn == wr_vpn) begin
        wr_match     = 1'b1;
        wr_match_idx = PTR_W'(i);
      end
    end
  end

  // Lookup above reads the pre-edge table, so a same-cycle write is invisible to it.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      for (int i = 0; i < ENTRIES; i++) tbl[i].valid <= 1'b0;
    end else if (wr_en) begin
      if (wr_match) begin
        tbl[wr_match_idx] <= '{valid: 1'b1, vpn: wr_vpn, ppn: wr_ppn};
      end else begin
        tbl[wr_ptr] <= '{valid: 1'b1, vpn: wr_vpn, ppn: wr_ppn};
        wr_ptr      <= (wr_ptr == PTR_W'(ENTRIES - 1)) ? '0 : wr_ptr + 1'b1;
      end
    end
  end
endmodule

// File: rtl/cpu_fetch_responder.sv
// Fetch responder: iTLB translate, direct-mapped I-cache lookup, blocking line refill.
// Optional CPU_FETCH_PERF_EN adds saturating hit/miss counters.
module cpu_fetch_responder
  import cpu_fetch_pkg::*;
#(
  parameter int ITLB_ENTRIES     = ITLB_ENTRIES_DEF,
  parameter int PAGE_OFFSET_BITS = PAGE_OFFSET_BITS_DEF,
  parameter int ICACHE_LINES     = ICACHE_LINES_DEF,
  parameter int LINE_WORDS       = LINE_WORDS_DEF
) (
  input  logic clk,
  input  logic reset,
`ifdef CPU_FETCH_PERF_EN
  output logic [31:0] perf_hits,
  output logic [31:0] perf_misses,
`endif
  cpu_fetch_responder_if.slave bus
);
  localparam int WSEL_W     = $clog2(LINE_WORDS);
  localparam int IDX_W      = $clog2(ICACHE_LINES);
  localparam int LINE_OFF_W = BYTE_OFF_W + WSEL_W;

  fetch_state_e state, state_n;
  cache_line_t  cache [ICACHE_LINES];

  logic             itlb_hit;
  logic [PPN_W-1:0] itlb_ppn;
  logic             xlat_hit, line_hit;
  logic [PA_W-1:0]  pa, line_pa;
  logic [WSEL_W-1:0] wsel;
  logic [IDX_W-1:0]  idx, fill_idx;
  logic [TAG_W-1:0]  tag, fill_tag;

  logic               tlb_hit_q, tlb_hit_d, cache_hit_q, cache_hit_d, mem_req_q, mem_req_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PA_W-1:0]    next_pc_q, next_pc_d, mem_addr_q, mem_addr_d;
  logic               fill_en, miss_start;

  cpu_itlb #(.ENTRIES(ITLB_ENTRIES)) u_itlb (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (bus.tlb_write),
    .wr_vpn (bus.tlb_addr[VA_W-1:PAGE_OFFSET_BITS]),
    .wr_ppn (bus.tlb_data[PA_W-1:PAGE_OFFSET_BITS]),
    .lk_vpn (bus.pc[VA_W-1:PAGE_OFFSET_BITS]),
    .lk_hit (itlb_hit),
    .lk_ppn (itlb_ppn)
  );

  assign xlat_hit = bus.tlb_enable ? itlb_hit : 1'b1;
  assign pa       = bus.tlb_enable ? {itlb_ppn, bus.pc[PAGE_OFFSET_BITS-1:0]} : bus.pc;
  assign wsel     = pa[BYTE_OFF_W +: WSEL_W];
  assign idx      = pa[LINE_OFF_W +: IDX_W];
  assign tag      = pa[PA_W-1 -: TAG_W];
  assign line_pa  = {pa[PA_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
  assign line_hit = cache[idx].valid && (cache[idx].tag == tag);

  // The in-flight line address doubles as the fill index/tag source.
  assign fill_idx = mem_addr_q[LINE_OFF_W +: IDX_W];
  assign fill_tag = mem_addr_q[PA_W-1 -: TAG_W];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n     = state;
    tlb_hit_d   = xlat_hit;
    cache_hit_d = 1'b0;
    instr_d     = instr_q;
    next_pc_d   = bus.pc;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    fill_en     = 1'b0;
    miss_start  = 1'b0;
    case (state)
      IDLE: begin
        mem_req_d = 1'b0;
        if (!bus.exception && xlat_hit) begin
          if (line_hit) begin
            cache_hit_d = 1'b1;
            instr_d     = cache[idx].words[wsel];
            next_pc_d   = bus.jump ? bus.jump_pc : bus.pc + PA_W'(INSTR_BYTES);
          end else begin
            next_pc_d  = bus.jump ? bus.jump_pc : bus.pc;
            mem_req_d  = 1'b1;
            mem_addr_d = line_pa;
            miss_start = 1'b1;
            state_n    = REFILL;
          end
        end
      end
      REFILL: begin
        // Exception only affects next_pc; the memory handshake always completes.
        if (!bus.exception && bus.jump) next_pc_d = bus.jump_pc;
        if (bus.mem_ack) begin
          fill_en   = 1'b1;
          mem_req_d = 1'b0;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tlb_hit_q   <= 1'b0;
      cache_hit_q <= 1'b0;
      instr_q     <= '0;
      next_pc_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      tlb_hit_q   <= tlb_hit_d;
      cache_hit_q <= cache_hit_d;
      instr_q     <= instr_d;
      next_pc_q   <= next_pc_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ICACHE_LINES; i++) cache[i].valid <= 1'b0;
    end else if (fill_en) begin
      cache[fill_idx] <= '{valid: 1'b1, tag: fill_tag, words: bus.mem_data};
    end
  end

`ifdef CPU_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_hits   <= '0;
      perf_misses <= '0;
    end else begin
      if (cache_hit_d && perf_hits != '1)  perf_hits   <= perf_hits + 1'b1;
      if (miss_start && perf_misses != '1) perf_misses <= perf_misses + 1'b1;
    end
  end
`endif

  assign bus.tlb_hit   = tlb_hit_q;
  assign bus.cache_hit = cache_hit_q;
  assign bus.instr     = instr_q;
  assign bus.next_pc   = next_pc_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;

  logic unused_bits;
  assign unused_bits = ^{bus.tlb_addr[PAGE_OFFSET_BITS-1:0], bus.tlb_data[PAGE_OFFSET_BITS-1:0],
                         pa[BYTE_OFF_W-1:0], mem_addr_q[LINE_OFF_W-1:0]
`ifndef CPU_FETCH_PERF_EN
                         , miss_start
`endif
                        };
endmodule

// File: doc/cpu_fetch_responder.md
Name: cpu_fetch_responder

Overview:
- Responder side of the CPU fetch request/response interface.
- Consumes the requester's PC, jump, exception and iTLB-write signals. Returns tlb_hit, instr, cache_hit and next_pc.
- Contains a small fully-associative iTLB and a direct-mapped instruction cache. A blocking refill FSM fetches whole lines from the memory side.
- Sits between the PC/decode control logic and the instruction memory port.

Parameters:
- ITLB_ENTRIES, 4, iTLB entries, power of 2.
- PAGE_OFFSET_BITS, 12, untranslated low address bits.
- ICACHE_LINES, 8, direct-mapped cache lines, power of 2.
- LINE_WORDS, 4, instructions per line, power of 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- tlb_enable  in  1  translate pc through iTLB
- tlb_write  in  1  write one iTLB entry this cycle
- tlb_addr  in  `VIRTUAL_ADDR_WIDTH  virtual address for the iTLB write (VPN taken from it)
- tlb_data  in  `PHYSICAL_ADDR_WIDTH  physical address for the iTLB write (PPN taken from it)
- pc  in  `PHYSICAL_ADDR_WIDTH  fetch address (virtual when tlb_enable=1)
- jump  in  1  redirect request
- jump_pc  in  `PHYSICAL_ADDR_WIDTH  redirect target
- exception  in  1  flush fetch
- tlb_hit  out  1  translation valid
- instr  out  `INSTR_WIDTH  fetched instruction
- cache_hit  out  1  instr valid this cycle
- next_pc  out  `PHYSICAL_ADDR_WIDTH  PC for the requester to present next
- mem_req  out  1  line refill request
- mem_addr  out  `PHYSICAL_ADDR_WIDTH  line-aligned physical address
- mem_ack  in  1  refill data valid, single beat
- mem_data  in  LINE_WORDS*`INSTR_WIDTH  full line, word 0 in the LSBs

Behaviour:
- Reset:
  - All iTLB and cache valid bits cleared; round-robin iTLB write pointer set to 0; FSM set to IDLE.
  - Outputs: tlb_hit=0, cache_hit=0, instr=0, next_pc=0, mem_req=0, mem_addr=0.
- Latency: all outputs are registered. The response to the pc sampled at edge N appears after edge N.
- Translation:
  - tlb_enable=0: PA = pc, tlb_hit=1.
  - tlb_enable=1: VPN = pc[VA-1:PAGE_OFFSET_BITS], matched against all valid entries. On a hit, PA = {PPN, pc offset}. On a miss, tlb_hit=0, cache_hit=0, next_pc=pc, and no refill is issued.
- iTLB write: tlb_write=1 writes {VPN, PPN, valid} into the entry at the write pointer, then the pointer increments and wraps. If that VPN is already present, the matching entry is overwritten in place instead and the pointer does not move.
- A write and a lookup in the same cycle: the lookup sees the old contents.
- Cache indexing:
  - word select = PA[log2(INSTR_WIDTH/8) +: log2(LINE_WORDS)];
  - index = the next log2(ICACHE_LINES) bits;
  - tag = the remaining upper bits.
- FSM:
  - IDLE, cache hit: cache_hit=1, instr = selected word, next_pc = jump ? jump_pc : pc + INSTR_WIDTH/8.
  - IDLE, cache miss with tlb_hit=1: cache_hit=0, next_pc=pc; assert mem_req with mem_addr = line-aligned PA; go to REFILL.
  - REFILL: hold mem_req and mem_addr stable until mem_ack. On mem_ack, write the line, tag and valid; drop mem_req; go to IDLE. The next lookup of that pc hits.
- jump during a miss: next_pc=jump_pc, and the refill that is already in flight still completes.
- exception (highest priority):
  - cache_hit=0 and next_pc=pc for that cycle.
  - In IDLE, no refill is started.
  - In REFILL, mem_req is held until mem_ack, the returned data is written normally, then the FSM returns to IDLE. The handshake is never abandoned.
- PC arithmetic: pc + INSTR_WIDTH/8 wraps modulo 2^PHYSICAL_ADDR_WIDTH.
- Reset mid-REFILL: mem_req drops on the next edge; a late mem_ack arriving in IDLE is ignored.

Optional Feature:
- Macro: CPU_FETCH_PERF_EN.
- Defined:
  - Adds outputs perf_hits and perf_misses, 32 bits each, reset to 0.
  - perf_hits increments on each cycle with cache_hit=1.
  - perf_misses increments on each IDLE-to-REFILL transition.
  - Both saturate at all-ones.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- CPU_define.vh holds the widths.
- A shared package cpu_fetch_pkg holds:
  - the FSM state enum {IDLE, REFILL};
  - the iTLB entry struct {valid, vpn, ppn};
  - the cache line struct {valid, tag, words};
  - INSTR_BYTES = INSTR_WIDTH/8.
- One natural sub-module: cpu_itlb, holding the associative match, the write pointer and the overwrite-on-match logic.

Test Plan:
- After reset, tlb_enable=0, pc=0x100, cold cache -> mem_req=1 with mem_addr=0x100. mem_ack with words {A,B,C,D} -> next lookup of pc=0x104 gives cache_hit=1, instr=B, next_pc=0x108.
- tlb_write with tlb_addr=0x3000, tlb_data=0x7000; then tlb_enable=1, pc=0x3008 -> tlb_hit=1, mem_addr=0x7000. A lookup of pc=0x4000 -> tlb_hit=0, mem_req stays 0.
- Five iTLB writes with distinct VPNs -> the entry written first is evicted, its lookup misses, and the other four hit.
- On a hit at pc=0x104 with jump=1, jump_pc=0x200 -> next_pc=0x200.
- exception asserted while in REFILL -> mem_req held until mem_ack, cache_hit=0 for that cycle, the line is still written, FSM back in IDLE.
- pc at the maximum aligned address, hit -> next_pc=0. With CPU_FETCH_PERF_EN defined, 3 hits and 1 miss -> perf_hits=3, perf_misses=1.
